// File: rtl/dalu_seq.sv
// dalu_seq: request sequencer in front of the 16-bit dALU.
//
// Accepts one request at a time. Narrow (16-bit) requests are issued to the
// ALU unchanged. Wide (32-bit) ADD/SUB requests run as two ALU passes: the
// low word with ADD/SUB, then the high word with ADC/SUC carrying the
// low-word carry/borrow. Any other wide op is rejected with done+err.
// Whenever no pass is executing, the sequencer drives OP_NOP to the ALU.
//
// Optional feature macro: DALU_SEQ_CMP32_EN
//   Defined: wide CMP (op 9) runs SUB low / SUC high as an unsigned compare.
//   Undefined: wide CMP is rejected like any other illegal wide op.
//
// Parameters:
//   OP_NOP  - ALU op code that performs no update
//   ALU_LAT - edges from the ALU op-sampling edge until its outputs may be
//             captured (1..3)
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, wide, op, a, b,
//   cf_in                    - request; sampled only when accepted (busy=0)
//   busy, done, err          - in-flight flag, completion/reject pulses
//   result, c_out, z_out,
//   o_out                    - registered result and flags
//   alu_a, alu_b, alu_op,
//   alu_cf                   - registered ALU inputs
//   alu_acc, alu_c,
//   alu_c_flag, alu_z_flag,
//   alu_o_flag               - ALU outputs
module dalu_seq #(
  parameter logic [7:0] OP_NOP  = 8'h00,
  parameter int         ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wide,
  input  logic [7:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cf_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        c_out,
  output logic        z_out,
  output logic        o_out,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [7:0]  alu_op,
  output logic        alu_cf,
  input  logic [15:0] alu_acc,
  input  logic [15:0] alu_c,
  input  logic        alu_c_flag,
  input  logic        alu_z_flag,
  input  logic        alu_o_flag
);

  localparam logic [7:0] OP_ADD  = 8'd1;
  localparam logic [7:0] OP_ADC  = 8'd2;
  localparam logic [7:0] OP_SUB  = 8'd3;
  localparam logic [7:0] OP_SUC  = 8'd4;
  localparam logic [7:0] OP_MUL6 = 8'd6;
  localparam logic [7:0] OP_DIV6 = 8'd8;
`ifdef DALU_SEQ_CMP32_EN
  localparam logic [7:0] OP_CMP  = 8'd9;
`endif
  localparam logic [1:0] LAT_LAST = 2'(ALU_LAT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_EXEC = 3'd1,
    ST_LO_WAIT = 3'd2,
    ST_HI_EXEC = 3'd3,
    ST_HI_WAIT = 3'd4
  } state_t;

  // Wide requests that the two-pass sequence can carry out.
  function automatic logic wide_legal(input logic [7:0] f);
`ifdef DALU_SEQ_CMP32_EN
    return (f == OP_ADD) || (f == OP_SUB) || (f == OP_CMP);
`else
    return (f == OP_ADD) || (f == OP_SUB);
`endif
  endfunction

  // Op issued for the first pass; a wide compare is a low-word subtract.
  function automatic logic [7:0] first_op(input logic w, input logic [7:0] f);
`ifdef DALU_SEQ_CMP32_EN
    return (w && (f == OP_CMP)) ? OP_SUB : f;
`else
    return (w ? f : f);
`endif
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;
  logic        wide_r, wide_s;
  logic [7:0]  op_r, op_s;
  logic [31:0] a_r, a_s;
  logic [31:0] b_r, b_s;
  logic [15:0] lo_r, lo_s;
  logic        zl_r, zl_s;
  logic        cl_r, cl_s;
  logic        busy_s, done_s, err_s;
  logic [31:0] result_s;
  logic        c_s, z_s, o_s;
  logic [15:0] alu_a_s, alu_b_s;
  logic [7:0]  alu_op_s;
  logic        alu_cf_s;
  logic        lat_hit_s, lo_cl_s, hi_cy_s, hi_eq_s;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    wide_s   = wide_r;
    op_s     = op_r;
    a_s      = a_r;
    b_s      = b_r;
    lo_s     = lo_r;
    zl_s     = zl_r;
    cl_s     = cl_r;
    busy_s   = busy;
    done_s   = 1'b0;
    err_s    = 1'b0;
    result_s = result;
    c_s      = c_out;
    z_s      = z_out;
    o_s      = o_out;
    alu_a_s  = alu_a;
    alu_b_s  = alu_b;
    alu_op_s = OP_NOP;
    alu_cf_s = alu_cf;

    lat_hit_s = (cnt_r == LAT_LAST);
    // The ALU sign-extends its operands, so its carry flag is not the
    // unsigned word carry; derive carry/borrow from the operands instead.
    lo_cl_s = (op_r == OP_ADD) ? (alu_acc < a_r[15:0]) : (a_r[15:0] < b_r[15:0]);
    hi_eq_s = (a_r[31:16] == b_r[31:16]);
    hi_cy_s = (op_r == OP_ADD) ?
              ((alu_acc < a_r[31:16]) | ((alu_acc == a_r[31:16]) & cl_r)) :
              ((a_r[31:16] < b_r[31:16]) | (hi_eq_s & cl_r));

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (!wide || wide_legal(op)) begin
            wide_s   = wide;
            op_s     = op;
            a_s      = a;
            b_s      = b;
            alu_a_s  = a[15:0];
            alu_b_s  = b[15:0];
            alu_op_s = first_op(wide, op);
            alu_cf_s = wide ? 1'b0 : cf_in;
            busy_s   = 1'b1;
            state_s  = ST_LO_EXEC;
          end else begin
            result_s = 32'h0000_0000;
            done_s   = 1'b1;
            err_s    = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LO_EXEC: begin
        cnt_s   = 2'd0;
        state_s = ST_LO_WAIT;
      end
      ST_LO_WAIT: begin
        if (!lat_hit_s) begin
          cnt_s = cnt_r + 2'd1;
        end else if (!wide_r) begin
          result_s = {((op_r == OP_MUL6) || (op_r == OP_DIV6)) ? alu_c : 16'h0000, alu_acc};
          c_s      = alu_c_flag;
          z_s      = alu_z_flag;
          o_s      = alu_o_flag;
          done_s   = 1'b1;
          busy_s   = 1'b0;
          state_s  = ST_IDLE;
        end else begin
          lo_s     = alu_acc;
          zl_s     = alu_z_flag;
          cl_s     = lo_cl_s;
          alu_a_s  = a_r[31:16];
          alu_b_s  = b_r[31:16];
          alu_op_s = (op_r == OP_ADD) ? OP_ADC : OP_SUC;
          alu_cf_s = lo_cl_s;
          state_s  = ST_HI_EXEC;
        end
      end
      ST_HI_EXEC: begin
        cnt_s   = 2'd0;
        state_s = ST_HI_WAIT;
      end
      ST_HI_WAIT: begin
        if (!lat_hit_s) begin
          cnt_s = cnt_r + 2'd1;
        end else begin
          result_s = {alu_acc, lo_r};
          c_s      = hi_cy_s;
          z_s      = zl_r & alu_z_flag;
          o_s      = alu_o_flag;
`ifdef DALU_SEQ_CMP32_EN
          if (op_r == OP_CMP) begin
            o_s = ~hi_cy_s & ~(zl_r & alu_z_flag);
          end else begin
            o_s = alu_o_flag;
          end
`endif
          done_s   = 1'b1;
          busy_s   = 1'b0;
          state_s  = ST_IDLE;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, request copy and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
      wide_r  <= 1'b0;
      op_r    <= 8'h00;
      a_r     <= 32'h0000_0000;
      b_r     <= 32'h0000_0000;
      lo_r    <= 16'h0000;
      zl_r    <= 1'b0;
      cl_r    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= 32'h0000_0000;
      c_out   <= 1'b0;
      z_out   <= 1'b0;
      o_out   <= 1'b0;
      alu_a   <= 16'h0000;
      alu_b   <= 16'h0000;
      alu_op  <= OP_NOP;
      alu_cf  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      wide_r  <= wide_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      lo_r    <= lo_s;
      zl_r    <= zl_s;
      cl_r    <= cl_s;
      busy    <= busy_s;
      done    <= done_s;
      err     <= err_s;
      result  <= result_s;
      c_out   <= c_s;
      z_out   <= z_s;
      o_out   <= o_s;
      alu_a   <= alu_a_s;
      alu_b   <= alu_b_s;
      alu_op  <= alu_op_s;
      alu_cf  <= alu_cf_s;
    end
  end

endmodule

// File: tb/tb_dalu_seq.sv
// tb_dalu_seq: self-checking bench for dalu_seq with a behavioural dALU
// model (ALU_LAT-edge pipeline) and a 32-bit arithmetic reference.
module tb_dalu_seq;

  localparam int         ALU_LAT = 1;
  localparam logic [7:0] OP_NOP  = 8'h00;

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] c;
    logic        cf;
    logic        zf;
    logic        of;
  } alu_t;

  typedef struct packed {
    logic        e;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  logic        clk, rst, start, wide, cf_in;
  logic [7:0]  op;
  logic [31:0] a, b;
  logic        busy, done, err, c_out, z_out, o_out;
  logic [31:0] result;
  logic [15:0] alu_a, alu_b, alu_acc, alu_c;
  logic [7:0]  alu_op;
  logic        alu_cf, alu_c_flag, alu_z_flag, alu_o_flag;

  int errors = 0;
  int checks = 0;

  dalu_seq #(.OP_NOP(OP_NOP), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .wide(wide), .op(op), .a(a), .b(b),
    .cf_in(cf_in), .busy(busy), .done(done), .err(err), .result(result),
    .c_out(c_out), .z_out(z_out), .o_out(o_out), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_cf(alu_cf), .alu_acc(alu_acc), .alu_c(alu_c),
    .alu_c_flag(alu_c_flag), .alu_z_flag(alu_z_flag), .alu_o_flag(alu_o_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dALU behaviour: operands are sign-extended for ADD/ADC/SUB/SUC.
  function automatic alu_t alu_fn(input logic [7:0] f, input logic [15:0] x,
                                  input logic [15:0] y, input logic ci);
    alu_t r;
    int sx, sy, s;
    logic [31:0] p;
    r = '0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    s = 0;
    p = 32'h0;
    case (f)
      8'd1: s = sx + sy;
      8'd2: s = sx + sy + int'(ci);
      8'd3: s = sx - sy;
      8'd4: s = sx - sy - int'(ci);
      8'd5: begin p = 32'(x[7:0]) * 32'(y[7:0]); r.acc = p[15:0]; end
      8'd6: begin p = 32'(x) * 32'(y); r.acc = p[15:0]; r.c = p[31:16]; end
      8'd7, 8'd8: begin
        if (y == 16'h0) begin r.acc = 16'hFFFF; r.c = x; end
        else begin r.acc = x / y; r.c = x % y; end
      end
      8'd9: r.acc = x - y;
      default: r.acc = 16'h0;
    endcase
    if (f >= 8'd1 && f <= 8'd4) begin
      r.acc = s[15:0];
      r.cf  = s[16];
      r.of  = (s > 32767) || (s < -32768);
    end
    if (f == 8'd9) begin
      r.cf = (x < y); r.zf = (x == y); r.of = (x > y);
    end else begin
      r.zf = (r.acc == 16'h0);
    end
    return r;
  endfunction

  // ALU model: ops sampled each edge, results appear ALU_LAT edges later.
  logic [7:0]  p_op [ALU_LAT];
  logic [15:0] p_a  [ALU_LAT];
  logic [15:0] p_b  [ALU_LAT];
  logic        p_cf [ALU_LAT];
  alu_t        alu_r;
  initial begin
    for (int i = 0; i < ALU_LAT; i++) begin
      p_op[i] = 8'h00; p_a[i] = 16'h0; p_b[i] = 16'h0; p_cf[i] = 1'b0;
    end
    alu_r = '0;
  end
  always @(posedge clk) begin
    p_op[0] <= alu_op; p_a[0] <= alu_a; p_b[0] <= alu_b; p_cf[0] <= alu_cf;
    for (int i = 1; i < ALU_LAT; i++) begin
      p_op[i] <= p_op[i-1]; p_a[i] <= p_a[i-1]; p_b[i] <= p_b[i-1]; p_cf[i] <= p_cf[i-1];
    end
    if (p_op[ALU_LAT-1] != OP_NOP)
      alu_r <= alu_fn(p_op[ALU_LAT-1], p_a[ALU_LAT-1], p_b[ALU_LAT-1], p_cf[ALU_LAT-1]);
  end
  assign alu_acc = alu_r.acc;
  assign alu_c = alu_r.c;
  assign alu_c_flag = alu_r.cf;
  assign alu_z_flag = alu_r.zf;
  assign alu_o_flag = alu_r.of;

  // Reference outcome of a whole request, from 32-bit arithmetic.
  function automatic exp_t ref_fn(input logic w, input logic [7:0] f,
                                  input logic [31:0] x, input logic [31:0] y, input logic ci);
    exp_t e;
    alu_t n;
    logic [32:0] s;
    e = '0;
    if (!w) begin
      n = alu_fn(f, x[15:0], y[15:0], ci);
      e.r = {(f == 8'd6 || f == 8'd8) ? n.c : 16'h0, n.acc};
      e.c = n.cf; e.z = n.zf; e.o = n.of;
    end else if (f == 8'd1) begin
      s = {1'b0, x} + {1'b0, y};
      e.r = s[31:0]; e.c = s[32]; e.z = (e.r == 32'h0);
      e.o = (x[31] == y[31]) && (e.r[31] != x[31]);
    end else if (f == 8'd3) begin
      s = {1'b0, x} - {1'b0, y};
      e.r = s[31:0]; e.c = (x < y); e.z = (e.r == 32'h0);
      e.o = (x[31] != y[31]) && (e.r[31] != x[31]);
`ifdef DALU_SEQ_CMP32_EN
    end else if (f == 8'd9) begin
      e.r = x - y; e.c = (x < y); e.z = (x == y); e.o = (x > y);
`endif
    end else begin
      e.e = 1'b1; e.r = 32'h0;
    end
    return e;
  endfunction

  // Edges after the accept edge until done is seen (reject pulses on the
  // accept edge itself, i.e. one cycle after start is presented).
  function automatic int exp_lat(input logic e, input logic w);
    if (e) return 0;
    return w ? 2 * (ALU_LAT + 2) : (ALU_LAT + 2);
  endfunction

  // Present one request, then watch the DUT until done (bounded).
  task automatic run_req(input logic w, input logic [7:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic ci, input logic poke,
                         output int lat, output int issues, output logic [7:0] l_op,
                         output logic [15:0] l_a, output logic [15:0] l_b, output logic l_cf);
    lat = -1; issues = 0; l_op = 8'h0; l_a = 16'h0; l_b = 16'h0; l_cf = 1'b0;
    start = 1'b1; wide = w; op = f; a = x; b = y; cf_in = ci;
    @(posedge clk); #1;
    start = 1'b0;
    wide = ($urandom_range(0, 1) != 0); op = 8'($urandom);
    a = $urandom; b = $urandom; cf_in = ($urandom_range(0, 1) != 0);
    for (int k = 0; k <= 30; k++) begin
      if (alu_op !== OP_NOP) begin
        issues++; l_op = alu_op; l_a = alu_a; l_b = alu_b; l_cf = alu_cf;
      end
      if (done === 1'b1) begin lat = k; break; end
      start = (poke && k == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wide = 1'b0; op = 8'h0; a = 32'h0; b = 32'h0; cf_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, c_out, z_out, o_out, alu_cf} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, err, c_out, z_out, o_out, alu_cf});
    end
    checks++;
    if ({result, alu_a, alu_b, alu_op} !== 72'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want zeros", result, alu_a, alu_b, alu_op);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (alu_op !== OP_NOP || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL idle_%0d: got op=%h busy=%b done=%b want 00 0 0", i, alu_op, busy, done);
      end
    end
  endtask

  task automatic test_narrow_add();
    int lat, iss; logic [7:0] lo; logic [15:0] la, lb; logic lc;
    run_req(1'b0, 8'd1, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, lat, iss, lo, la, lb, lc);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL nadd_lat: got %0d want 3", lat); end
    checks++;
    if (result !== 32'h0000_0007 || z_out !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL nadd_res: got %h z=%b err=%b want 00000007 z=0 err=0", result, z_out, err);
    end
    checks++;
    if (iss !== 1 || lo !== 8'h01) begin
      errors++; $display("FAIL nadd_pulse: got %0d cycles op=%h want 1 cycle op=01", iss, lo);
    end
  endtask

  task automatic test_wide_directed();
    logic [31:0] ta [4], tb [4], tr [4];
    logic [7:0]  top [4], thop [4];
    logic [2:0]  tf [4];
    int lat, iss; logic [7:0] lo; logic [15:0] la, lb; logic lc;
    ta = '{32'h0000_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
    tb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    top = '{8'd1, 8'd1, 8'd1, 8'd3};
    thop = '{8'd2, 8'd2, 8'd2, 8'd4};
    tr = '{32'h0001_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_FFFF};
    tf = '{3'b000, 3'b001, 3'b110, 3'b000};   // {c, z, o}
    for (int i = 0; i < 4; i++) begin
      run_req(1'b1, top[i], ta[i], tb[i], 1'b0, 1'b0, lat, iss, lo, la, lb, lc);
      checks++;
      if (lat !== 6 || err !== 1'b0) begin
        errors++; $display("FAIL wide%0d_lat: got %0d err=%b want 6 err=0", i, lat, err);
      end
      checks++;
      if (result !== tr[i] || {c_out, z_out, o_out} !== tf[i]) begin
        errors++; $display("FAIL wide%0d_res: got %h czo=%b want %h czo=%b", i, result, {c_out, z_out, o_out}, tr[i], tf[i]);
      end
      checks++;
      if (iss !== 2 || lo !== thop[i] || lc !== 1'b1 || la !== ta[i][31:16] || lb !== tb[i][31:16]) begin
        errors++; $display("FAIL wide%0d_hi: got n=%0d op=%h a=%h b=%h cf=%b want 2 %h %h %h 1",
                           i, iss, lo, la, lb, lc, thop[i], ta[i][31:16], tb[i][31:16]);
      end
    end
  endtask

  task automatic test_reject();
    logic [7:0] rops [3];
    int lat, iss; logic [7:0] lo; logic [15:0] la, lb; logic lc;
    exp_t e;
    rops = '{8'd5, 8'd2, 8'd9};
    for (int i = 0; i < 3; i++) begin
      e = ref_fn(1'b1, rops[i], 32'h1234_5678, 32'h0000_0010, 1'b0);
      run_req(1'b1, rops[i], 32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, lat, iss, lo, la, lb, lc);
      checks++;
      if (lat !== exp_lat(e.e, 1'b1) || err !== e.e || busy !== 1'b0) begin
        errors++; $display("FAIL rej%0d_timing: got lat=%0d err=%b busy=%b want %0d %b 0", i, lat, err, busy, exp_lat(e.e, 1'b1), e.e);
      end
      checks++;
      if (result !== e.r || (e.e && iss !== 0)) begin
        errors++; $display("FAIL rej%0d_res: got %h issues=%0d want %h", i, result, iss, e.r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       bw [4];
    logic [7:0] bo [4];
    int lat, iss; logic [7:0] lo; logic [15:0] la, lb; logic lc;
    exp_t e;
    bw = '{1'b0, 1'b1, 1'b1, 1'b0};
    bo = '{8'd6, 8'd5, 8'd3, 8'd8};
    for (int i = 0; i < 4; i++) begin
      e = ref_fn(bw[i], bo[i], 32'h0000_9ABC + i, 32'h0000_0123, 1'b0);
      run_req(bw[i], bo[i], 32'h0000_9ABC + i, 32'h0000_0123, 1'b0, 1'b0, lat, iss, lo, la, lb, lc);
      checks++;
      if (lat !== exp_lat(e.e, bw[i]) || err !== e.e || result !== e.r) begin
        errors++; $display("FAIL b2b%0d: got lat=%0d err=%b res=%h want %0d %b %h", i, lat, err, result, exp_lat(e.e, bw[i]), e.e, e.r);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, iss; logic [7:0] lo; logic [15:0] la, lb; logic lc;
    logic extra;
    exp_t e;
    e = ref_fn(1'b1, 8'd1, 32'h0012_8000, 32'h0034_8000, 1'b0);
    run_req(1'b1, 8'd1, 32'h0012_8000, 32'h0034_8000, 1'b0, 1'b1, lat, iss, lo, la, lb, lc);
    checks++;
    if (lat !== 6 || result !== e.r || c_out !== e.c || iss !== 2) begin
      errors++; $display("FAIL busy_ign_res: got lat=%0d res=%h c=%b n=%0d want 6 %h %b 2", lat, result, c_out, iss, e.r, e.c);
    end
    extra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || alu_op !== OP_NOP || busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL busy_ign_quiet: got activity=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    int lat, iss; logic [7:0] lo; logic [15:0] la, lb; logic lc;
    logic found, seen_done;
    exp_t e;
    start = 1'b1; wide = 1'b1; op = 8'd1; a = 32'h0000_FFFF; b = 32'h0000_0001; cf_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (alu_op === 8'd2) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL rstmid_hiexec: got found=0 want 1"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (alu_op !== OP_NOP || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: got op=%h busy=%b done=%b want 00 0 0", alu_op, busy, done);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone: got done pulse want none"); end
    e = ref_fn(1'b0, 8'd3, 32'h0000_0005, 32'h0000_0007, 1'b0);
    run_req(1'b0, 8'd3, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, lat, iss, lo, la, lb, lc);
    checks++;
    if (lat !== 3 || result !== 32'h0000_FFFE || c_out !== e.c) begin
      errors++; $display("FAIL rstmid_sub: got lat=%0d res=%h c=%b want 3 0000fffe %b", lat, result, c_out, e.c);
    end
  endtask

  task automatic test_random();
    int lat, iss; logic [7:0] lo; logic [15:0] la, lb; logic lc;
    logic w, ci; logic [7:0] f; logic [31:0] x, y;
    exp_t e;
    int sel;
    for (int n = 0; n < 60; n++) begin
      w = ($urandom_range(0, 1) != 0);
      sel = $urandom_range(0, 3);
      if (!w) f = 8'($urandom_range(1, 9));
      else if (sel == 0) f = 8'd1;
      else if (sel == 1) f = 8'd3;
      else if (sel == 2) f = 8'($urandom_range(0, 15));
      else f = 8'd1;
      x = $urandom; y = $urandom; ci = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 3) == 0) x = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) y = x;
      e = ref_fn(w, f, x, y, ci);
      run_req(w, f, x, y, ci, 1'b0, lat, iss, lo, la, lb, lc);
      checks++;
      if (lat !== exp_lat(e.e, w) || err !== e.e || result !== e.r ||
          (!e.e && {c_out, z_out, o_out} !== {e.c, e.z, e.o}) ||
          iss !== (e.e ? 0 : (w ? 2 : 1))) begin
        errors++;
        $display("FAIL rnd%0d w=%b op=%0d a=%h b=%h cf=%b: got lat=%0d err=%b res=%h czo=%b n=%0d want %0d %b %h %b",
                 n, w, f, x, y, ci, lat, err, result, {c_out, z_out, o_out}, iss,
                 exp_lat(e.e, w), e.e, e.r, {e.c, e.z, e.o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_narrow_add();
    test_wide_directed();
    test_reject();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dalu_seq.md
Name: dalu_seq

Overview:
- Sequencer in front of the 16-bit dALU.
- Accepts one request at a time from the control unit.
- Narrow (16-bit) requests pass straight through to the ALU.
- Wide (32-bit) ADD/SUB requests run as two ALU passes: low word with ADD/SUB, then high word with ADC/SUC carrying the low-word carry/borrow.
- Owns the ALU op/operand inputs; drives the NOP op whenever the ALU is not executing.

Parameters:
- OP_NOP, 8'h00, ALU op code driven when idle; the ALU performs no update for this code.
- ALU_LAT, 1, edges from the op-sampling edge until ALU outputs are valid to capture; legal range 1..3.

Ports:
- clk  in  1  clock; everything on posedge
- rst  in  1  synchronous reset, active-high
- start  in  1  request strobe; accepted only when busy=0
- wide  in  1  1 = 32-bit request
- op  in  8  ALU op code: 1 ADD, 2 ADC, 3 SUB, 4 SUC, 5 MUL8, 6 MUL6, 7 DIV8, 8 DIV6, 9 CMP
- a  in  32  operand A; low 16 bits only when narrow
- b  in  32  operand B; low 16 bits only when narrow
- cf_in  in  1  carry-in for narrow ADC/SUC
- busy  out  1  request in flight
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when the request was rejected
- result  out  32  result, valid from done until the next accept
- c_out  out  1  carry/borrow (CMP: a<b)
- z_out  out  1  zero (CMP: a==b)
- o_out  out  1  signed overflow (CMP: a>b)
- alu_a  out  16  to ALU a
- alu_b  out  16  to ALU b
- alu_op  out  8  to ALU op
- alu_cf  out  1  to ALU cf
- alu_acc  in  16  from ALU acc
- alu_c  in  16  from ALU c
- alu_c_flag  in  1  from ALU c_flag
- alu_z_flag  in  1  from ALU z_flag
- alu_o_flag  in  1  from ALU o_flag

Behaviour:
- Reset: state IDLE; alu_op=OP_NOP; alu_a/alu_b/alu_cf=0; busy=done=err=0; result=0; flags=0. Reset mid-operation aborts with no done pulse.
- All outputs are registered.
- States: IDLE, LO_EXEC, LO_WAIT, HI_EXEC, HI_WAIT.
- IDLE + start, narrow, or wide with op in {1,3}:
  - Load the low operand halves into alu_a/alu_b and op into alu_op.
  - alu_cf = cf_in if narrow, else 0.
  - busy<=1, go to LO_EXEC.
- IDLE + start, wide, any other op: no ALU issue; next edge result<=0, done<=1, err<=1; busy stays 0.
- EXEC states: the ALU samples on the next edge; at that edge alu_op<=OP_NOP; go to the matching WAIT state.
- WAIT states: hold ALU_LAT-1 further cycles, then capture on the following edge.
- LO_WAIT capture, narrow:
  - result[15:0]=alu_acc.
  - result[31:16]=alu_c for op 6/8, else 0.
  - c_out/z_out/o_out = ALU flags.
  - done<=1, busy<=0, go to IDLE.
- LO_WAIT capture, wide:
  - Save lo=alu_acc and zl=alu_z_flag.
  - Compute cl: ADD carry = (alu_acc < a[15:0]) unsigned; SUB borrow = (a[15:0] < b[15:0]).
  - Do not use alu_c_flag for the low-word carry; the ALU sign-extends operands.
  - Issue the high halves with alu_op = ADC (ADD) or SUC (SUB), alu_cf=cl; go to HI_EXEC.
- HI_WAIT capture:
  - result={alu_acc, lo}; z_out = zl & alu_z_flag; o_out = alu_o_flag (signed 32-bit overflow).
  - c_out, ADD: (alu_acc < a[31:16]) | (alu_acc==a[31:16] & cl).
  - c_out, SUB: (a[31:16] < b[31:16]) | (a[31:16]==b[31:16] & cl).
  - done<=1, busy<=0.
- Latency, start edge to done high: narrow 1+ALU_LAT+1 edges (3 at default); wide 2*(ALU_LAT+1)+... precisely 6 at default.
- Back-to-back: start in the same cycle as done (busy=0) is accepted.
- start while busy=1 is ignored.
- a/b/op/wide/cf_in are sampled only at accept; the sequencer holds its own copy.

Optional Feature:
- Macro DALU_SEQ_CMP32_EN.
- Defined: wide CMP (op 9) is legal.
  - Runs SUB low, then SUC high.
  - Unsigned compare: lt = 32-bit borrow; eq = zl & high z; gt = !lt & !eq.
  - Outputs: z_out=eq, c_out=lt, o_out=gt; result = difference.
- Undefined: wide CMP rejected with err like other illegal wide ops.

Test Plan:
- Reset, then idle 5 cycles -> alu_op stays 0x00, busy=0, done never pulses.
- Narrow ADD a=0x0003, b=0x0004 -> done 3 cycles after the accept edge; result=0x00000007, z=0; alu_op pulses 0x01 for exactly one cycle.
- Wide ADD a=0x0000FFFF, b=0x00000001 -> ALU sees ADD(FFFF,0001) then ADC(0000,0000,cf=1); result=0x00010000, c=0, z=0, o=0.
- Wide ADD 0x7FFFFFFF+1 -> result 0x80000000, o=1, c=0. Wide ADD 0xFFFFFFFF+1 -> result 0x00000000, z=1, c=1, o=0.
- Wide SUB 0x00010000-1 -> ALU sees SUC with cf=1; result 0x0000FFFF, c=0. Wide MUL8 -> done+err after 1 cycle, alu_op never leaves 0x00.
- Reset asserted during HI_EXEC of a wide ADD -> no done; alu_op=0x00 next cycle. A new narrow SUB 5-7 after reset -> result 0x0000FFFE, c_out = ALU flag.
